// File: rtl/ifmap_buffer_pkg.sv
// Shared IFmap sizing defaults, common to the address generator and the ring buffer.
package ifmap_buffer_pkg;
  localparam int IFMAP_DATA_WIDTH  = 16;
  localparam int IFMAP_DEPTH       = 16;
  localparam int IFMAP_ADDR_WIDTH  = 4;
  localparam int IFMAP_FILTER_SIZE = 4;
endpackage

// File: rtl/ifmap_buffer_if.sv
// Buffer-side bus: write stream, generator read port, release request and occupancy status.
interface ifmap_buffer_if
  import ifmap_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = IFMAP_DATA_WIDTH,
  parameter int ADDR_WIDTH = IFMAP_ADDR_WIDTH
);
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_err;
  logic                  rel_en;
  logic [ADDR_WIDTH:0]   rel_num;
  logic [ADDR_WIDTH-1:0] tail_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  empty;
  logic                  full;
  logic                  win_ready;

  modport master (
    output wr_data, wr_valid, rd_en, rd_addr, rel_en, rel_num,
    input  wr_ready, rd_data, rd_valid, rd_err, tail_ptr, count, empty, full, win_ready
  );

  modport slave (
    input  wr_data, wr_valid, rd_en, rd_addr, rel_en, rel_num,
    output wr_ready, rd_data, rd_valid, rd_err, tail_ptr, count, empty, full, win_ready
  );
endinterface

// File: rtl/ifmap_buf_mem.sv
// Simple dual-port RAM: one write port, one registered read port, read-before-write, no reset.
module ifmap_buf_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data_p1
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_p1 <= mem[rd_addr];
  end
endmodule

// File: rtl/ifmap_buffer.sv
// Circular IFmap ring buffer feeding the address generator; rd_addr is an absolute ring index.
// Optional range check of read addresses against occupancy: define IFMAP_BUF_RD_CHECK_EN.
module ifmap_buffer
  import ifmap_buffer_pkg::*;
#(
  parameter int DATA_WIDTH  = IFMAP_DATA_WIDTH,
  parameter int DEPTH       = IFMAP_DEPTH,
  parameter int ADDR_WIDTH  = IFMAP_ADDR_WIDTH,
  parameter int FILTER_SIZE = IFMAP_FILTER_SIZE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  ifmap_buffer_if.slave bus
);
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] tail;
  logic [ADDR_WIDTH:0]   cnt;
  logic [ADDR_WIDTH:0]   eff;
  logic                  wr_fire;
  logic                  full_w;
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] q_p1;

  // Over-release saturates at current occupancy so count never underflows.
  function automatic logic [ADDR_WIDTH:0] sat_release(input logic [ADDR_WIDTH:0] req,
                                                      input logic [ADDR_WIDTH:0] avail);
    return (req > avail) ? avail : req;
  endfunction

  assign full_w  = (cnt == (ADDR_WIDTH+1)'(DEPTH));
  assign wr_fire = bus.wr_valid && !full_w;
  assign eff     = bus.rel_en ? sat_release(bus.rel_num, cnt) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (wr_fire) wptr <= wptr + 1'b1;
      tail <= tail + eff[ADDR_WIDTH-1:0];
      cnt  <= cnt + {{ADDR_WIDTH{1'b0}}, wr_fire} - eff;
    end
  end

  ifmap_buf_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk        (clk),
    .wr_en      (wr_fire && !flush),
    .wr_addr    (wptr),
    .wr_data    (bus.wr_data),
    .rd_en      (bus.rd_en),
    .rd_addr    (bus.rd_addr),
    .rd_data_p1 (q_p1)
  );

  // p0 -> p1: read request registered alongside the RAM output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_p1 <= 1'b0;
    else      vld_p1 <= bus.rd_en && !flush;
  end

`ifdef IFMAP_BUF_RD_CHECK_EN
  logic [ADDR_WIDTH-1:0] rd_off;
  logic                  rd_err_p1;

  // Offset from the oldest entry, modulo the ring, must fall inside the occupied span.
  assign rd_off = bus.rd_addr - tail;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_err_p1 <= 1'b0;
    else      rd_err_p1 <= bus.rd_en && !flush && !({1'b0, rd_off} < cnt);
  end

  assign bus.rd_err = rd_err_p1;
`else
  assign bus.rd_err = 1'b0;
`endif

  // RAM has no reset; gating with the valid keeps rd_data at 0 after reset and lost reads.
  assign bus.rd_data   = vld_p1 ? q_p1 : '0;
  assign bus.rd_valid  = vld_p1;
  assign bus.wr_ready  = !full_w;
  assign bus.tail_ptr  = tail;
  assign bus.count     = cnt;
  assign bus.empty     = (cnt == '0);
  assign bus.full      = full_w;
  assign bus.win_ready = (cnt >= (ADDR_WIDTH+1)'(FILTER_SIZE));
endmodule

// File: tb/tb_ifmap_buffer.sv
// Directed bench for ifmap_buffer with a reference ring model and a read-result scoreboard.
module tb_ifmap_buffer;
  import ifmap_buffer_pkg::*;

  localparam int DW = IFMAP_DATA_WIDTH;
  localparam int AW = IFMAP_ADDR_WIDTH;
  localparam int D  = IFMAP_DEPTH;
  localparam int FS = IFMAP_FILTER_SIZE;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  ifmap_buffer_if bus ();

  ifmap_buffer dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_mem [D];
  int            m_wptr  = 0;
  int            m_tail  = 0;
  int            m_count = 0;
  logic [DW-1:0] exp_data_q [$];
  logic          exp_err_q  [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input int addr);
`ifdef IFMAP_BUF_RD_CHECK_EN
    int off;
    off = (addr - m_tail + D) % D;
    return !(off < m_count);
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle_inputs();
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_en    = 1'b0;
    bus.rd_addr  = '0;
    bus.rel_en   = 1'b0;
    bus.rel_num  = '0;
    flush        = 1'b0;
  endtask

  task automatic check_state();
    chk("count",     bus.count,     m_count);
    chk("tail_ptr",  bus.tail_ptr,  m_tail);
    chk("empty",     bus.empty,     m_count == 0);
    chk("full",      bus.full,      m_count == D);
    chk("wr_ready",  bus.wr_ready,  m_count != D);
    chk("win_ready", bus.win_ready, m_count >= FS);
  endtask

  // One clock with the currently driven inputs: update the model, clock, then compare.
  task automatic cycle();
    bit fire;
    int eff;
    bit pend;
    pend = 1'b0;
    if (bus.rd_en && !flush) begin
      exp_data_q.push_back(m_mem[bus.rd_addr]);
      exp_err_q.push_back(model_err(int'(bus.rd_addr)));
      pend = 1'b1;
    end
    fire = bus.wr_valid && (m_count < D);
    eff  = bus.rel_en ? ((int'(bus.rel_num) > m_count) ? m_count : int'(bus.rel_num)) : 0;
    if (flush) begin
      m_wptr = 0; m_tail = 0; m_count = 0;
    end else begin
      if (fire) begin
        m_mem[m_wptr] = bus.wr_data;
        m_wptr = (m_wptr + 1) % D;
      end
      m_tail  = (m_tail + eff) % D;
      m_count = m_count + int'(fire) - eff;
    end
    @(posedge clk);
    #1;
    idle_inputs();
    check_state();
    chk("rd_valid", bus.rd_valid, pend);
    if (bus.rd_valid) begin
      if (exp_data_q.size() > 0) begin
        chk("rd_data", bus.rd_data, exp_data_q.pop_front());
        chk("rd_err",  bus.rd_err,  exp_err_q.pop_front());
      end else begin
        chk("rd_unexpected", bus.rd_valid, 1'b0);
      end
    end
  endtask

  task automatic wr(input logic [DW-1:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    cycle();
  endtask

  task automatic rd(input int a);
    bus.rd_en   = 1'b1;
    bus.rd_addr = AW'(a);
    cycle();
  endtask

  task automatic rel(input int n);
    bus.rel_en  = 1'b1;
    bus.rel_num = (AW+1)'(n);
    cycle();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cycle();
  endtask

  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_ready",  bus.wr_ready,  1'b1);
    chk("rst_rd_data",   bus.rd_data,   16'h0000);
    chk("rst_rd_valid",  bus.rd_valid,  1'b0);
    chk("rst_tail",      bus.tail_ptr,  0);
    chk("rst_count",     bus.count,     0);
    chk("rst_empty",     bus.empty,     1'b1);
    chk("rst_full",      bus.full,      1'b0);
    chk("rst_win_ready", bus.win_ready, 1'b0);
    chk("rst_rd_err",    bus.rd_err,    1'b0);
    rst = 1'b1;
    @(negedge clk);

    // Fill to full, then a rejected 17th write
    for (int i = 0; i < D; i++) wr(DW'(i));
    chk("fill_full",     bus.full,     1'b1);
    chk("fill_wr_ready", bus.wr_ready, 1'b0);
    chk("fill_count",    bus.count,    16);
    wr(16'hBEEF);
    chk("over_count", bus.count, 16);

    // Read addr 5 after fill, then back-to-back reads including slot 0 (not overwritten)
    rd(5);
    chk("rd5_data", bus.rd_data, 16'h0005);
    rd(0);
    rd(15);
    cycle();

    // Flush while a read and a write are requested
    bus.rd_en = 1'b1; bus.rd_addr = 4'd3;
    bus.wr_valid = 1'b1; bus.wr_data = 16'h5555;
    do_flush();
    chk("flush_count", bus.count, 0);

    // Release 2 with a concurrent write at count 15
    for (int i = 0; i < D - 1; i++) wr(DW'(16'h0100 + i));
    bus.wr_valid = 1'b1; bus.wr_data = 16'h01FF;
    rel(2);
    chk("relw_count", bus.count, 14);
    chk("relw_tail",  bus.tail_ptr, 2);

    // Wrap: full ring, release 4, refill with 0xA0..0xA3 (first write reads its slot's old data)
    do_flush();
    for (int i = 0; i < D; i++) wr(DW'(i));
    rel(4);
    bus.rd_en = 1'b1; bus.rd_addr = 4'd0;
    wr(16'h00A0);
    chk("rbw_data", bus.rd_data, 16'h0000);
    wr(16'h00A1);
    wr(16'h00A2);
    wr(16'h00A3);
    rd(1);
    chk("wrap_data", bus.rd_data, 16'h00A1);
    chk("wrap_tail", bus.tail_ptr, 4);

    // Over-release clamps; same-cycle read of a released entry still returns it
    do_flush();
    wr(16'h0C00); wr(16'h0C01); wr(16'h0C02);
    bus.rd_en = 1'b1; bus.rd_addr = 4'd1;
    rel(8);
    chk("clamp_count", bus.count, 0);
    chk("clamp_empty", bus.empty, 1'b1);
    chk("clamp_tail",  bus.tail_ptr, 3);
    chk("clamp_data",  bus.rd_data, 16'h0C01);

    // Out-of-window and in-window reads with count 4, tail 0
    do_flush();
    for (int i = 0; i < 4; i++) wr(DW'(16'h0D00 + i));
    rd(6);
`ifdef IFMAP_BUF_RD_CHECK_EN
    chk("rderr_out", bus.rd_err, 1'b1);
`else
    chk("rderr_out", bus.rd_err, 1'b0);
`endif
    rd(2);
    chk("rderr_in", bus.rd_err, 1'b0);

    // Asynchronous reset mid-read drops the in-flight result
    bus.rd_en = 1'b1; bus.rd_addr = 4'd1;
    @(posedge clk);
    #1;
    idle_inputs();
    rst = 1'b0;
    #1;
    chk("arst_rd_valid", bus.rd_valid, 1'b0);
    chk("arst_rd_data",  bus.rd_data,  16'h0000);
    chk("arst_count",    bus.count,    0);
    chk("arst_tail",     bus.tail_ptr, 0);
    exp_data_q.delete();
    exp_err_q.delete();
    m_wptr = 0; m_tail = 0; m_count = 0;
    @(negedge clk);
    rst = 1'b1;
    wr(16'h0E00);
    rd(0);
    chk("post_rst_data", bus.rd_data, 16'h0E00);

    chk("sb_drain", exp_data_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
